clint_mmio: RTL
===============

// Module: clint_mmio
// PURPOSE
// - Memory-mapped core-local interruptor that sits upstream of the CSR file and drives its timer-interrupt input tint.
// - Holds the 64-bit mtime counter, the mtimecmp compare register and the msip bit, all reachable over a single-outstanding valid/ready bus.
// - Timer interrupt: tint = registered (mtime >= mtimecmp) gated by mstatus.MIE and mie.MTIE, which the CSR file supplies.
// PARAMETERS
// - TICK_DIV   default 1    clk cycles per mtime increment; legal range 1..65535.
// - BASE_ADDR  default 0    base of the 64 KiB window; req_addr is an offset within it.
// PORTS
// - clk         in   1   single clock; every flop is on posedge clk
// - rst         in   1   reset, synchronous, active-high
// - req_valid   in   1   bus request valid
// - req_ready   out  1   block accepts a request; high only in IDLE
// - req_we      in   1   1 = write, 0 = read
// - req_addr    in   16  byte offset, 8-byte aligned; addr[2:0] ignored
// - req_wdata   in   64  write data
// - req_wstrb   in   8   byte-lane write enables
// - resp_valid  out  1   response valid
// - resp_ready  in   1   consumer accepts the response
// - resp_rdata  out  64  read data; 0 for writes
// - resp_err    out  1   set when the address is unmapped
// - mie_en      in   1   mstatus.MIE from the CSR file
// - mtie_en     in   1   mie.MTIE from the CSR file
// - tint        out  1   timer interrupt request to the CSR file
// - msip        out  1   software interrupt pending (msip[0])
// BEHAVIOUR
// - Reset values:
//   - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, mtip_q = 0, prescaler count = 0, state = IDLE.
//   - Outputs: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, tint = 0.
// - Address map (offset):
//   - 0x0000 msip: bit 0 writable; other bits read 0.
//   - 0x4000 mtimecmp.
//   - 0xBFF8 mtime.
//   - Any other offset: reads return 0, writes are dropped, resp_err = 1.
// - Prescaler:
//   - Counts 0..TICK_DIV-1; tick pulses for one cycle when the count is TICK_DIV-1, then the count wraps to 0.
//   - TICK_DIV = 1 gives tick every cycle.
// - mtime:
//   - Increments by 1 on tick and wraps from 2^64-1 to 0.
//   - A bus write to mtime in the same cycle as a tick wins: new value = merged wdata, no increment that cycle.
// - Writes: per-byte merge; byte i is updated only if req_wstrb[i]; wstrb = 0 writes nothing. The write takes effect on the accept edge.
// - Interrupt logic:
//   - mtip_q <= (mtime >= mtimecmp), unsigned 64-bit compare on current register values.
//   - tint = mtip_q & mie_en & mtie_en, combinational from mtip_q.
//   - Latency: mtime or mtimecmp change -> mtip_q one cycle later; mie_en or mtie_en change -> tint the same cycle.
//   - tint is a level. It drops when the CSR file clears MIE on trap entry, or after software rewrites mtimecmp above mtime (one cycle later).
// - Bus FSM, states IDLE and RESP:
//   - IDLE: req_ready = 1. On req_valid, sample we/addr/data, perform the write or capture the read data, go to RESP.
//   - RESP: resp_valid = 1. resp_rdata and resp_err stay stable until resp_ready, then return to IDLE. No new request is accepted in RESP.
//   - Read data is the register value at the accept edge, before any same-edge tick.
//   - Back-to-back throughput: one request per 2 cycles.
// - Reset mid-transaction: a pending response is discarded, FSM returns to IDLE, registers take reset values.
// STRUCTURE
// - Package clint_pkg: address constants MSIP_OFF, MTIMECMP_OFF, MTIME_OFF; state localparams IDLE and RESP; MTIMECMP_RST.
// - Sub-module clint_prescaler (parameter TICK_DIV; ports clk, rst, tick).
// - Top level: FSM, register file, byte merge, compare.
// TESTING
// - Reset, then idle 5 cycles with TICK_DIV = 1 -> mtime reads 5 (read accepted on cycle 5); tint = 0; mtimecmp reads all-ones.
// - Write mtimecmp = 20, mie_en = mtie_en = 1 -> tint rises on the cycle after mtime reaches 20; drop mie_en -> tint falls the same cycle.
// - Write mtime = 64'hFFFF_FFFF_FFFF_FFFF, wstrb = 8'hFF -> next tick gives 0; the mtime write takes priority over the coincident tick.
// - Write mtimecmp with wstrb = 8'h0F, wdata = 64'h1122_3344_5566_7788 over all-ones -> reads 64'hFFFF_FFFF_5566_7788.
// - Read offset 0x1000 -> resp_rdata = 0, resp_err = 1; hold resp_ready = 0 for 3 cycles -> response stable, req_ready = 0 throughout.
// - Write msip = 1 then assert rst during RESP -> resp_valid = 0 next cycle, msip = 0; TICK_DIV = 4 -> mtime increments every 4th cycle.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared constants, bus FSM states and the byte-lane merge helper for the CLINT.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clint_pkg;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    function automatic logic [63:0] byte_merge(input logic [63:0] cur,
                                               input logic [63:0] wdata,
                                               input logic [7:0]  wstrb);
        logic [63:0] res;
        res = cur;
        for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk down to a one-cycle mtime tick every TICK_DIV cycles.
// Latency: first tick on the TICK_DIV-th cycle after reset.
// Backpressure: none; free-running.
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/clint_mmio.sv
// Core-local interruptor: mtime/mtimecmp/msip over a single-outstanding valid/ready bus.
// Latency: response one cycle after accept; tint follows a compare change by one cycle.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
module clint_mmio
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    input  logic        mie_en,
    input  logic        mtie_en,
    output logic        tint,
    output logic        msip
);

    if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_div
        $error("clint_mmio: TICK_DIV out of range");
    end
    // The bus only ever sees the 16-bit offset, so the window must be 64 KiB aligned.
    if (BASE_ADDR[15:0] != 16'd0) begin : g_bad_base
        $error("clint_mmio: BASE_ADDR not 64 KiB aligned");
    end

    state_t      state, state_nxt;
    logic        tick, accept, wr;
    logic        hit_msip, hit_cmp, hit_time, unmapped;
    logic [63:0] mtime, mtimecmp, rd_mux, rdata_q;
    logic        msip_q, err_q, mtip_q;
    logic [63:0] msip_merged;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[2:0];

    clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign hit_msip = (req_addr[15:3] == MSIP_OFF[15:3]);
    assign hit_cmp  = (req_addr[15:3] == MTIMECMP_OFF[15:3]);
    assign hit_time = (req_addr[15:3] == MTIME_OFF[15:3]);
    assign unmapped = !(hit_msip || hit_cmp || hit_time);

    assign accept = req_valid && req_ready;
    assign wr     = accept && req_we;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        if (hit_msip)      rd_mux = {63'd0, msip_q};
        else if (hit_cmp)  rd_mux = mtimecmp;
        else if (hit_time) rd_mux = mtime;
    end

    assign msip_merged = byte_merge({63'd0, msip_q}, req_wdata, req_wstrb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rdata_q <= req_we ? 64'd0 : rd_mux;
                err_q   <= unmapped;
            end
        end
    end

    // A bus write to mtime overrides the increment of a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime    <= '0;
            mtimecmp <= MTIMECMP_RST;
            msip_q   <= 1'b0;
            mtip_q   <= 1'b0;
        end else begin
            if (wr && hit_time)  mtime <= byte_merge(mtime, req_wdata, req_wstrb);
            else if (tick)       mtime <= mtime + 64'd1;
            if (wr && hit_cmp)   mtimecmp <= byte_merge(mtimecmp, req_wdata, req_wstrb);
            if (wr && hit_msip)  msip_q <= msip_merged[0];
            mtip_q <= (mtime >= mtimecmp);
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign tint       = mtip_q & mie_en & mtie_en;
    assign msip       = msip_q;

endmodule
